// File: rtl/huffman_decoder.sv
// rtl/huffman_decoder.sv - serial Huffman bitstream decoder driven by an encoder-published code table
//
// Purpose:
//   Latches six (code, mask) table entries from the Huffman encoder and
//   validates them. It then decodes a serial code bitstream, root bit first,
//   back into gray symbols SYM_BASE .. SYM_BASE+5.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   code_valid            one-cycle pulse: latch HC1..HC6 / M1..M6
//   HC1..HC6 [7:0]        code of entry i, bit[L-1] is the first bit on the wire
//   M1..M6   [7:0]        mask of entry i, 2^L-1 for a code of length L
//   bit_valid, bit_in     serial code bit and its qualifier
//   bit_last              final bit of the stream (only meaningful with bit_valid)
//   ready                 table accepted, decoder consuming bits
//   sym_valid, sym_data   one-cycle decoded symbol pulse; sym_data holds between pulses
//   sym_total [15:0]      symbols decoded since last table load, saturating
//   done                  one-cycle pulse with the final symbol of a clean stream
//   err                   sticky: bad table, no-match or truncated stream

module huffman_decoder #(
    parameter int MAXLEN   = 7,
    parameter int SYM_BASE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        code_valid,
    input  logic [7:0]  HC1,
    input  logic [7:0]  HC2,
    input  logic [7:0]  HC3,
    input  logic [7:0]  HC4,
    input  logic [7:0]  HC5,
    input  logic [7:0]  HC6,
    input  logic [7:0]  M1,
    input  logic [7:0]  M2,
    input  logic [7:0]  M3,
    input  logic [7:0]  M4,
    input  logic [7:0]  M5,
    input  logic [7:0]  M6,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        bit_last,
    output logic        ready,
    output logic        sym_valid,
    output logic [7:0]  sym_data,
    output logic [15:0] sym_total,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] MAXLEN_C   = 4'(MAXLEN);
    localparam logic [7:0] SYM_BASE_C = 8'(SYM_BASE);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, ERR} state_t;

    state_t     state;
    logic [7:0] hc_q  [6];
    logic [7:0] m_q   [6];
    logic [3:0] len_q [6];
    logic [3:0] max_len;
    logic [6:0] sh;
    logic [3:0] len;

    logic [7:0] hc_in [6];
    logic [7:0] m_in  [6];

    assign hc_in[0] = HC1;
    assign hc_in[1] = HC2;
    assign hc_in[2] = HC3;
    assign hc_in[3] = HC4;
    assign hc_in[4] = HC5;
    assign hc_in[5] = HC6;
    assign m_in[0]  = M1;
    assign m_in[1]  = M2;
    assign m_in[2]  = M3;
    assign m_in[3]  = M4;
    assign m_in[4]  = M5;
    assign m_in[5]  = M6;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int b = 0; b < 8; b++) begin
            c = c + {3'd0, v[b]};
        end
        return c;
    endfunction

    // Table validation on the latched entries (evaluated while in CHECK).
    logic [3:0] l_chk [6];
    logic [5:0] legal;
    logic [3:0] max_calc;
    logic       table_ok;
    logic [8:0] full_mask;

    always_comb begin
        max_calc  = 4'd0;
        legal     = 6'd0;
        full_mask = 9'd0;
        for (int i = 0; i < 6; i++) begin
            l_chk[i]  = popcount8(m_q[i]);
            // A legal mask is a contiguous run of ones starting at bit 0.
            full_mask = (9'd1 << l_chk[i]) - 9'd1;
            legal[i]  = (m_q[i] == full_mask[7:0]) &&
                        (l_chk[i] >= 4'd1) && (l_chk[i] <= MAXLEN_C) &&
                        ((hc_q[i] & ~m_q[i]) == 8'd0);
            if (l_chk[i] > max_calc) begin
                max_calc = l_chk[i];
            end
        end
        table_ok = &legal;
    end

    // Candidate code after appending the incoming bit.
    logic [7:0] nsh;
    logic [3:0] nlen;
    logic       hit;
    logic [2:0] hit_idx;

    always_comb begin
        nsh     = {sh, bit_in};
        nlen    = len + 4'd1;
        hit     = 1'b0;
        hit_idx = 3'd0;
        // Walk downward so the lowest matching entry wins on a corrupt table.
        for (int i = 5; i >= 0; i--) begin
            if ((nlen == len_q[i]) && ((nsh & m_q[i]) == hc_q[i])) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b0;
            sym_valid <= 1'b0;
            sym_data  <= 8'd0;
            sym_total <= 16'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            sh        <= 7'd0;
            len       <= 4'd0;
            max_len   <= 4'd0;
            for (int i = 0; i < 6; i++) begin
                hc_q[i]  <= 8'd0;
                m_q[i]   <= 8'd0;
                len_q[i] <= 4'd0;
            end
        end else begin
            sym_valid <= 1'b0;
            done      <= 1'b0;
            if (code_valid) begin
                // Reload wins over everything, including a bit in the same cycle.
                for (int i = 0; i < 6; i++) begin
                    hc_q[i] <= hc_in[i];
                    m_q[i]  <= m_in[i];
                end
                sh        <= 7'd0;
                len       <= 4'd0;
                sym_total <= 16'd0;
                err       <= 1'b0;
                ready     <= 1'b0;
                state     <= CHECK;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    CHECK: begin
                        for (int i = 0; i < 6; i++) begin
                            len_q[i] <= l_chk[i];
                        end
                        max_len <= max_calc;
                        if (table_ok) begin
                            ready <= 1'b1;
                            state <= RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                    RUN: begin
                        if (bit_valid) begin
                            if (hit) begin
                                sym_valid <= 1'b1;
                                sym_data  <= SYM_BASE_C + {5'd0, hit_idx};
                                if (sym_total != 16'hFFFF) begin
                                    sym_total <= sym_total + 16'd1;
                                end
                                sh  <= 7'd0;
                                len <= 4'd0;
                                if (bit_last) begin
                                    done  <= 1'b1;
                                    ready <= 1'b0;
                                    state <= IDLE;
                                end
                            end else if (bit_last || (nlen >= max_len)) begin
                                // Truncated stream or a code no entry can complete.
                                err   <= 1'b1;
                                ready <= 1'b0;
                                sh    <= 7'd0;
                                len   <= 4'd0;
                                state <= ERR;
                            end else begin
                                sh  <= nsh[6:0];
                                len <= nlen;
                            end
                        end
                    end
                    ERR: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// tb/tb_huffman_decoder.sv - scoreboard testbench for huffman_decoder with randomized symbol streams

module tb_huffman_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [7:0]  hc_d [6];
    logic [7:0]  m_d  [6];
    logic        bit_valid;
    logic        bit_in;
    logic        bit_last;
    logic        ready;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic [15:0] sym_total;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    huffman_decoder #(.MAXLEN(7), .SYM_BASE(1)) dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(hc_d[0]), .HC2(hc_d[1]), .HC3(hc_d[2]),
        .HC4(hc_d[3]), .HC5(hc_d[4]), .HC6(hc_d[5]),
        .M1(m_d[0]), .M2(m_d[1]), .M3(m_d[2]),
        .M4(m_d[3]), .M5(m_d[4]), .M6(m_d[5]),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_last(bit_last),
        .ready(ready), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_total(sym_total), .done(done), .err(err)
    );

    typedef struct {
        logic [7:0] sym;
        logic       last;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference table: symbol s (0-based) emits gray value s+1.
    logic [7:0] tbl_hc [6] = '{8'h01, 8'h00, 8'h03, 8'h04, 8'h0B, 8'h0A};
    logic [7:0] tbl_m  [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (sym_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sym got data=%0d done=%0d expected no symbol", sym_data, done);
                end else begin
                    e = q.pop_front();
                    if (sym_data !== e.sym || done !== e.last || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL sym got data=%0d done=%0d cyc=%0d expected data=%0d done=%0d cyc=%0d",
                                 sym_data, done, cyc, e.sym, e.last, e.cyc);
                    end
                end
            end else if (done) begin
                checks++;
                errors++;
                $display("FAIL done_without_sym got done=1 expected done=0");
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int code_len(input int s);
        int n = 0;
        for (int b = 0; b < 8; b++) n += int'(tbl_m[s][b]);
        return n;
    endfunction

    task automatic load_table(input bit expect_ok);
        for (int i = 0; i < 6; i++) begin
            hc_d[i] = tbl_hc[i];
            m_d[i]  = tbl_m[i];
        end
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hc_d[i] = 8'($urandom);
            m_d[i]  = 8'($urandom);
        end
        chk("ready_latency_1", 32'(ready), 32'd0);
        tick();
        chk("ready_after_load", 32'(ready), 32'(expect_ok));
        chk("err_after_load", 32'(err), 32'(!expect_ok));
    endtask

    task automatic send_symbol(input int s, input bit last, input bit gaps);
        int l = code_len(s);
        for (int k = 0; k < l; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom);
                    bit_last  = 1'($urandom);
                    tick();
                end
            end
            bit_valid = 1'b1;
            bit_in    = tbl_hc[s][l-1-k];
            bit_last  = last && (k == l - 1);
            if (k == l - 1) q.push_back('{8'(s + 1), last, cyc + 1});
            tick();
            bit_valid = 1'b0;
            bit_last  = 1'b0;
        end
    endtask

    task automatic send_raw(input bit b, input bit last);
        bit_valid = 1'b1;
        bit_in    = b;
        bit_last  = last;
        tick();
        bit_valid = 1'b0;
        bit_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) tick();
        chk(name, 32'(q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym_data", 32'(sym_data), 32'd0);
        chk("rst_sym_total", 32'(sym_total), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        int n;
        int s;
        int last_s;
        reset      = 1'b1;
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        bit_last   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hc_d[i] = 8'd0;
            m_d[i]  = 8'd0;
        end
        tick();
        tick();
        chk_reset_outputs();
        reset = 1'b0;
        tick();

        // Full table walk: symbols 1..6 in order.
        load_table(1'b1);
        for (int i = 0; i < 6; i++) send_symbol(i, i == 5, 1'b0);
        drain("walk_queue_empty");
        chk("walk_sym_total", 32'(sym_total), 32'd6);
        chk("walk_sym_data_hold", 32'(sym_data), 32'd6);
        chk("walk_ready_idle", 32'(ready), 32'd0);
        chk("walk_err", 32'(err), 32'd0);

        // Back-to-back 1-bit codes.
        load_table(1'b1);
        for (int i = 0; i < 4; i++) send_symbol(0, i == 3, 1'b0);
        drain("b2b_queue_empty");
        chk("b2b_sym_total", 32'(sym_total), 32'd4);

        // Truncated stream: 0,1 then end.
        load_table(1'b1);
        send_raw(1'b0, 1'b0);
        send_raw(1'b1, 1'b1);
        tick();
        chk("trunc_err", 32'(err), 32'd1);
        chk("trunc_ready", 32'(ready), 32'd0);
        chk("trunc_sym_total", 32'(sym_total), 32'd0);
        send_raw(1'b1, 1'b0);
        tick();
        chk("err_sticky", 32'(err), 32'd1);

        // Bad table: non-contiguous mask on entry 3.
        tbl_m[2] = 8'h05;
        load_table(1'b0);
        tick();
        chk("bad_ready_stays", 32'(ready), 32'd0);
        chk("bad_err_stays", 32'(err), 32'd1);
        tbl_m[2] = 8'h07;
        load_table(1'b1);

        // Reset after two bits of symbol 4.
        send_raw(1'b0, 1'b0);
        send_raw(1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs();
        load_table(1'b1);
        send_symbol(1, 1'b1, 1'b0);
        drain("post_reset_queue_empty");
        chk("post_reset_sym_data", 32'(sym_data), 32'd2);

        // Reload in the same cycle as a bit: the bit must be dropped.
        load_table(1'b1);
        for (int i = 0; i < 6; i++) begin
            hc_d[i] = tbl_hc[i];
            m_d[i]  = tbl_m[i];
        end
        code_valid = 1'b1;
        bit_valid  = 1'b1;
        bit_in     = 1'b1;
        tick();
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        chk("collide_ready_1", 32'(ready), 32'd0);
        tick();
        chk("collide_ready_2", 32'(ready), 32'd1);
        drain("collide_queue_empty");
        chk("collide_sym_total", 32'(sym_total), 32'd0);

        // Randomized streams with idle gaps and junk on bit_in/bit_last while idle.
        for (int it = 0; it < 25; it++) begin
            load_table(1'b1);
            n = $urandom_range(1, 15);
            last_s = 0;
            for (int k = 0; k < n; k++) begin
                s = $urandom_range(0, 5);
                last_s = s;
                send_symbol(s, k == n - 1, 1'b1);
            end
            drain("rand_queue_empty");
            chk("rand_sym_total", 32'(sym_total), 32'(n));
            chk("rand_sym_data_hold", 32'(sym_data), 32'(last_s + 1));
            chk("rand_ready_idle", 32'(ready), 32'd0);
            chk("rand_err", 32'(err), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
